// File: rtl/write_arbiter_guard.sv
// rtl/write_arbiter_guard.sv - round-robin write arbiter with per-ID address-range guard and lockout
//
// Purpose: four requesters compete for one memory write port. The winner's
// address is checked against a per-ID authorization window; authorized writes
// go to the memory port, blocked writes raise an alert. Repeated violations
// lock a requester out until it is explicitly unlocked.
//
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   req[3:0], req_addr, req_data       level requests with packed 4-bit addr/data per ID
//   gnt[3:0]                           one-cycle one-hot capture pulse
//   cfg_we, cfg_idx, cfg_en, cfg_lo,
//   cfg_hi                             authorization table write
//   unlock[3:0]                        per-ID clear of lockout and violation count
//   mem_wr_valid/addr/data/id,
//   mem_wr_ready                       memory write port
//   alert_valid/id/addr/data,
//   alert_ack                          blocked-write report
//   lockout[3:0]                       per-ID lockout flags
//   busy                               high whenever the FSM is not idle
module write_arbiter_guard #(
  parameter int LOCK_THRESH = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_data,
  output logic [3:0]  gnt,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_idx,
  input  logic        cfg_en,
  input  logic [3:0]  cfg_lo,
  input  logic [3:0]  cfg_hi,
  input  logic [3:0]  unlock,
  output logic        mem_wr_valid,
  output logic [3:0]  mem_wr_addr,
  output logic [3:0]  mem_wr_data,
  output logic [1:0]  mem_wr_id,
  input  logic        mem_wr_ready,
  output logic        alert_valid,
  output logic [1:0]  alert_id,
  output logic [3:0]  alert_addr,
  output logic [3:0]  alert_data,
  input  logic        alert_ack,
  output logic [3:0]  lockout,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_ISSUE = 2'd2,
    S_ALERT = 2'd3
  } state_t;

  localparam logic [2:0] LP_THRESH = 3'(LOCK_THRESH);

  state_t      r_state;
  state_t      w_next;

  logic [1:0]  r_last;
  logic [1:0]  r_id;
  logic [3:0]  r_addr;
  logic [3:0]  r_data;
  logic [3:0]  r_gnt;
  logic [3:0]  r_lock;

  logic        r_en [4];
  logic [3:0]  r_lo [4];
  logic [3:0]  r_hi [4];
  logic [2:0]  r_viol [4];

  logic [3:0]  w_elig;
  logic        w_found;
  logic [1:0]  w_win;
  logic [1:0]  w_cand;
  logic        w_auth;
  logic        w_alert_done;
  logic [2:0]  w_viol_next;

  assign w_elig = req & ~r_lock;

  // Round-robin search starting just after the previous winner; k=4 wraps
  // back to r_last itself so a lone requester can win repeatedly.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_last;
    w_cand  = r_last;
    for (int k = 1; k <= 4; k++) begin
      w_cand = r_last + 2'(k);
      if (!w_found && w_elig[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  // Uses the registered table, so a cfg write during CHECK only lands at the
  // edge ending CHECK. lo > hi naturally yields an empty window.
  assign w_auth = r_en[r_id] && (r_lo[r_id] <= r_addr) && (r_addr <= r_hi[r_id]);

  assign w_alert_done = (r_state == S_ALERT) && alert_ack;
  assign w_viol_next  = (r_viol[r_id] == 3'd7) ? 3'd7 : r_viol[r_id] + 3'd1;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_next = S_CHECK;
      S_CHECK: w_next = w_auth ? S_ISSUE : S_ALERT;
      S_ISSUE: if (mem_wr_ready) w_next = S_IDLE;
      S_ALERT: if (alert_ack) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 2'd3;
      r_id   <= '0;
      r_addr <= '0;
      r_data <= '0;
      r_gnt  <= '0;
    end else begin
      r_gnt <= '0;
      if (r_state == S_IDLE && w_found) begin
        r_gnt  <= 4'b0001 << w_win;
        r_last <= w_win;
        r_id   <= w_win;
        r_addr <= req_addr[4*w_win +: 4];
        r_data <= req_data[4*w_win +: 4];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        r_en[i] <= 1'b0;
        r_lo[i] <= '0;
        r_hi[i] <= '0;
      end
    end else if (cfg_we) begin
      r_en[cfg_idx] <= cfg_en;
      r_lo[cfg_idx] <= cfg_lo;
      r_hi[cfg_idx] <= cfg_hi;
    end
  end

  // Unlock has priority over a coincident violation increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock <= '0;
      for (int i = 0; i < 4; i++) begin
        r_viol[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (unlock[i]) begin
          r_viol[i] <= '0;
          r_lock[i] <= 1'b0;
        end else if (w_alert_done && r_id == 2'(i)) begin
          r_viol[i] <= w_viol_next;
          if (w_viol_next >= LP_THRESH) begin
            r_lock[i] <= 1'b1;
          end
        end
      end
    end
  end

  assign gnt          = r_gnt;
  assign mem_wr_valid = (r_state == S_ISSUE);
  assign mem_wr_addr  = r_addr;
  assign mem_wr_data  = r_data;
  assign mem_wr_id    = r_id;
  assign alert_valid  = (r_state == S_ALERT);
  assign alert_id     = r_id;
  assign alert_addr   = r_addr;
  assign alert_data   = r_data;
  assign lockout      = r_lock;
  assign busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_write_arbiter_guard.sv
// tb/tb_write_arbiter_guard.sv - randomized self-checking bench for write_arbiter_guard
module tb_write_arbiter_guard;

  localparam int THRESH = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] req_addr;
  logic [15:0] req_data;
  logic [3:0]  gnt;
  logic        cfg_we;
  logic [1:0]  cfg_idx;
  logic        cfg_en;
  logic [3:0]  cfg_lo;
  logic [3:0]  cfg_hi;
  logic [3:0]  unlock;
  logic        mem_wr_valid;
  logic [3:0]  mem_wr_addr;
  logic [3:0]  mem_wr_data;
  logic [1:0]  mem_wr_id;
  logic        mem_wr_ready;
  logic        alert_valid;
  logic [1:0]  alert_id;
  logic [3:0]  alert_addr;
  logic [3:0]  alert_data;
  logic        alert_ack;
  logic [3:0]  lockout;
  logic        busy;

  write_arbiter_guard #(.LOCK_THRESH(THRESH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req(req), .req_addr(req_addr), .req_data(req_data), .gnt(gnt),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en), .cfg_lo(cfg_lo), .cfg_hi(cfg_hi),
    .unlock(unlock),
    .mem_wr_valid(mem_wr_valid), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_id(mem_wr_id), .mem_wr_ready(mem_wr_ready),
    .alert_valid(alert_valid), .alert_id(alert_id), .alert_addr(alert_addr),
    .alert_data(alert_data), .alert_ack(alert_ack),
    .lockout(lockout), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: authorization table, violation counts, lockouts, last winner.
  bit         m_en [4];
  int         m_lo [4];
  int         m_hi [4];
  int         m_viol [4];
  logic [3:0] m_lock;
  int         m_last;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_reset;
    for (int i = 0; i < 4; i++) begin
      m_en[i] = 1'b0; m_lo[i] = 0; m_hi[i] = 0; m_viol[i] = 0;
    end
    m_lock = 4'b0000;
    m_last = 3;
  endtask

  task automatic model_unlock(input logic [3:0] unl);
    for (int i = 0; i < 4; i++) begin
      if (unl[i]) begin
        m_viol[i] = 0;
        m_lock[i] = 1'b0;
      end
    end
  endtask

  task automatic cfg_write(input logic [1:0] idx, input bit en, input int lo, input int hi);
    cfg_we = 1'b1; cfg_idx = idx; cfg_en = en; cfg_lo = 4'(lo); cfg_hi = 4'(hi);
    tick;
    cfg_we = 1'b0;
    m_en[idx] = en; m_lo[idx] = lo; m_hi[idx] = hi;
    check("cfg_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_out(input bit auth, input int w, input logic [3:0] a, input logic [3:0] d);
    check("mem_valid", {31'd0, mem_wr_valid}, {31'd0, auth});
    check("alert_valid", {31'd0, alert_valid}, {31'd0, !auth});
    if (auth) begin
      check("mem_id", {30'd0, mem_wr_id}, w);
      check("mem_addr", {28'd0, mem_wr_addr}, {28'd0, a});
      check("mem_data", {28'd0, mem_wr_data}, {28'd0, d});
    end else begin
      check("alert_id", {30'd0, alert_id}, w);
      check("alert_addr", {28'd0, alert_addr}, {28'd0, a});
      check("alert_data", {28'd0, alert_data}, {28'd0, d});
    end
  endtask

  // One request round. Optional table write lands in the CHECK cycle; unlock
  // mask is applied on the completing edge (or on the idle edge if nobody wins).
  task automatic txn(input logic [3:0] rq, input logic [15:0] ad, input logic [15:0] dt,
                     input bit cw, input logic [1:0] ci, input bit ce, input int cl, input int ch,
                     input int stall, input logic [3:0] unl);
    logic [3:0] elig;
    int         w;
    bit         auth;
    logic [3:0] a;
    logic [3:0] d;
    req = rq; req_addr = ad; req_data = dt;
    elig = rq & ~m_lock;
    if (elig == 4'b0000) begin
      unlock = unl;
      tick;
      unlock = 4'b0000; req = 4'b0000;
      model_unlock(unl);
      check("idle_gnt", {28'd0, gnt}, 32'd0);
      check("idle_busy", {31'd0, busy}, 32'd0);
      check("idle_lockout", {28'd0, lockout}, {28'd0, m_lock});
      return;
    end
    w = -1;
    for (int k = 1; k <= 4; k++) begin
      if (w < 0 && elig[(m_last + k) % 4]) w = (m_last + k) % 4;
    end
    m_last = w;
    a = ad[4*w +: 4];
    d = dt[4*w +: 4];
    auth = m_en[w] && (m_lo[w] <= int'(a)) && (int'(a) <= m_hi[w]);
    tick;
    req = 4'b0000;
    check("gnt", {28'd0, gnt}, 32'd1 << w);
    check("gnt_busy", {31'd0, busy}, 32'd1);
    check("chk_valids", {30'd0, mem_wr_valid, alert_valid}, 32'd0);
    if (cw) begin
      cfg_we = 1'b1; cfg_idx = ci; cfg_en = ce; cfg_lo = 4'(cl); cfg_hi = 4'(ch);
    end
    tick;
    if (cw) begin
      cfg_we = 1'b0;
      m_en[ci] = ce; m_lo[ci] = cl; m_hi[ci] = ch;
    end
    check("gnt_cleared", {28'd0, gnt}, 32'd0);
    check_out(auth, w, a, d);
    for (int s = 0; s < stall; s++) begin
      tick;
      check_out(auth, w, a, d);
    end
    if (auth) mem_wr_ready = 1'b1;
    else      alert_ack = 1'b1;
    unlock = unl;
    tick;
    mem_wr_ready = 1'b0; alert_ack = 1'b0; unlock = 4'b0000;
    if (!auth) begin
      m_viol[w] = (m_viol[w] >= 7) ? 7 : m_viol[w] + 1;
      if (m_viol[w] >= THRESH) m_lock[w] = 1'b1;
    end
    model_unlock(unl);
    check("done_valids", {30'd0, mem_wr_valid, alert_valid}, 32'd0);
    check("done_busy", {31'd0, busy}, 32'd0);
    check("lockout", {28'd0, lockout}, {28'd0, m_lock});
  endtask

  initial begin
    rst_n = 1'b0;
    req = '0; req_addr = '0; req_data = '0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_en = 1'b0; cfg_lo = '0; cfg_hi = '0;
    unlock = '0; mem_wr_ready = 1'b0; alert_ack = 1'b0;
    model_reset;
    tick;
    tick;
    rst_n = 1'b1;
    tick;
    check("rst_gnt", {28'd0, gnt}, 32'd0);
    check("rst_valids", {30'd0, mem_wr_valid, alert_valid}, 32'd0);
    check("rst_lockout", {28'd0, lockout}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);

    // Unconfigured ID2: three alerts lock it, a fourth request is ignored.
    for (int r = 0; r < 3; r++) begin
      txn(4'b0100, 16'h0300, 16'h0a00, 1'b0, 2'd0, 1'b0, 0, 0, r, 4'b0000);
    end
    check("lock_after_3", {28'd0, lockout}, 32'h4);
    txn(4'b0100, 16'h0300, 16'h0a00, 1'b0, 2'd0, 1'b0, 0, 0, 0, 4'b0000);

    // Unlock, two violations, then unlock coinciding with the third ack.
    txn(4'b0000, 16'h0000, 16'h0000, 1'b0, 2'd0, 1'b0, 0, 0, 0, 4'b0100);
    txn(4'b0100, 16'h0300, 16'h0000, 1'b0, 2'd0, 1'b0, 0, 0, 0, 4'b0000);
    txn(4'b0100, 16'h0300, 16'h0000, 1'b0, 2'd0, 1'b0, 0, 0, 0, 4'b0000);
    txn(4'b0100, 16'h0300, 16'h0000, 1'b0, 2'd0, 1'b0, 0, 0, 1, 4'b0100);
    check("unlock_wins", {28'd0, lockout}, 32'h0);
    txn(4'b0100, 16'h0300, 16'h0000, 1'b0, 2'd0, 1'b0, 0, 0, 0, 4'b0000);
    txn(4'b0100, 16'h0300, 16'h0000, 1'b0, 2'd0, 1'b0, 0, 0, 0, 4'b0000);
    check("count_cleared", {28'd0, lockout}, 32'h0);
    txn(4'b0000, 16'h0000, 16'h0000, 1'b0, 2'd0, 1'b0, 0, 0, 0, 4'b0100);

    // ID1 window 4..8, addr 6 data 9, ready held low for 3 cycles.
    cfg_write(2'd1, 1'b1, 4, 8);
    txn(4'b0010, 16'h0060, 16'h0090, 1'b0, 2'd0, 1'b0, 0, 0, 3, 4'b0000);

    // Inverted window on ID0; widening it during CHECK only helps the next write.
    cfg_write(2'd0, 1'b1, 9, 2);
    txn(4'b0001, 16'h0005, 16'h0007, 1'b1, 2'd0, 1'b1, 0, 15, 0, 4'b0000);
    txn(4'b0001, 16'h0005, 16'h0007, 1'b0, 2'd0, 1'b0, 0, 0, 0, 4'b0000);

    // All open, all requesting: rotation 0,1,2,3,0 after forcing last winner to 3.
    for (int i = 0; i < 4; i++) cfg_write(2'(i), 1'b1, 0, 15);
    txn(4'b1000, 16'h1234, 16'h5678, 1'b0, 2'd0, 1'b0, 0, 0, 0, 4'b0000);
    for (int r = 0; r < 5; r++) begin
      txn(4'b1111, 16'hfedc, 16'hba98, 1'b0, 2'd0, 1'b0, 0, 0, 0, 4'b0000);
    end

    // Reset in the middle of an alert.
    cfg_write(2'd2, 1'b0, 0, 0);
    req = 4'b0100; req_addr = 16'h0300; req_data = 16'h0100;
    m_last = 2;
    tick;
    req = 4'b0000;
    check("rstmid_gnt", {28'd0, gnt}, 32'h4);
    tick;
    check("rstmid_alert", {31'd0, alert_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_drop", {30'd0, mem_wr_valid, alert_valid}, 32'd0);
    check("rstmid_busy", {31'd0, busy}, 32'd0);
    check("rstmid_lockout", {28'd0, lockout}, 32'd0);
    model_reset;
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    txn(4'b0010, 16'h0050, 16'h0020, 1'b0, 2'd0, 1'b0, 0, 0, 0, 4'b0000);
    for (int r = 0; r < 3; r++) begin
      txn(4'b0100, 16'h0300, 16'h0000, 1'b0, 2'd0, 1'b0, 0, 0, 0, 4'b0000);
    end
    check("rstmid_count", {28'd0, lockout}, 32'h4);

    // Randomized rounds.
    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        cfg_write(2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
                  $urandom_range(0, 15), $urandom_range(0, 15));
      end
      txn(4'($urandom), 16'($urandom), 16'($urandom),
          ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)), 1'($urandom),
          $urandom_range(0, 15), $urandom_range(0, 15),
          $urandom_range(0, 3),
          ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
